// File: rtl/maze_inj_pkg.sv
// maze_inj_pkg: shared widths, packet struct and lock states for the injection buffer
package maze_inj_pkg;
  localparam int TYPE_W = 2;
  localparam int ID_W = 6;
  localparam int FLIT_W = 8;
  localparam logic QOS_LO = 1'b0;
  localparam logic QOS_HI = 1'b1;
  typedef struct packed {
    logic              qos;
    logic [TYPE_W-1:0] typ;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
  } pkt_t;
  localparam int PKT_W = $bits(pkt_t);
  typedef enum logic [1:0] {ST_ARB, ST_LOCK_LO, ST_LOCK_HI} lock_t;
endpackage

// File: rtl/maze_sync_fifo.sv
// maze_sync_fifo: single-clock FIFO with registered occupancy count
module maze_sync_fifo #(
  parameter int W = 23,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rd_ptr];
  // storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/maze_inj_buf.sv
// maze_inj_buf: two-QoS injection buffer with locked arbitration and low-QoS starvation guard
module maze_inj_buf
  import maze_inj_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkt_in_vld,
  input  logic                       pkt_in_qos,
  input  logic [TYPE_W-1:0]          pkt_in_type,
  input  logic [ID_W-1:0]            pkt_in_src,
  input  logic [ID_W-1:0]            pkt_in_tgt,
  input  logic [FLIT_W-1:0]          pkt_in_data,
  output logic                       pkt_in_rdy,
  output logic                       inj_vld,
  output logic                       inj_qos,
  output logic [TYPE_W-1:0]          inj_type,
  output logic [ID_W-1:0]            inj_src,
  output logic [ID_W-1:0]            inj_tgt,
  output logic [FLIT_W-1:0]          inj_data,
  input  logic                       inj_rdy,
  output logic [$clog2(DEPTH+1)-1:0] hi_cnt,
  output logic [$clog2(DEPTH+1)-1:0] lo_cnt
);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  pkt_t in_pkt, hi_head, lo_head, out_pkt;
  logic hi_full, lo_full, hi_empty, lo_empty;
  logic push_hi, push_lo, pop_hi, pop_lo, sel_hi;
  lock_t state, state_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  assign in_pkt = {pkt_in_qos, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data};
  assign pkt_in_rdy = !hi_full && !lo_full;
  assign push_hi = pkt_in_vld && pkt_in_rdy && pkt_in_qos == QOS_HI;
  assign push_lo = pkt_in_vld && pkt_in_rdy && pkt_in_qos == QOS_LO;
  assign {inj_qos, inj_type, inj_src, inj_tgt, inj_data} = out_pkt;

  maze_sync_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_hi (
    .clk(clk), .rst_n(rst_n), .push(push_hi), .din(in_pkt), .pop(pop_hi),
    .dout(hi_head), .full(hi_full), .empty(hi_empty), .cnt(hi_cnt)
  );

  maze_sync_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_lo (
    .clk(clk), .rst_n(rst_n), .push(push_lo), .din(in_pkt), .pop(pop_lo),
    .dout(lo_head), .full(lo_full), .empty(lo_empty), .cnt(lo_cnt)
  );

  // arbitration: a stalled selection stays locked, otherwise starved low beats high beats low
  always_comb begin
    sel_hi = state == ST_LOCK_HI ? 1'b1 :
             state == ST_LOCK_LO ? 1'b0 :
             (!lo_empty && starve_cnt == SMAX) ? 1'b0 : !hi_empty;
    inj_vld = state != ST_ARB || !hi_empty || !lo_empty;
    out_pkt = !inj_vld ? '0 : sel_hi ? hi_head : lo_head;
    pop_hi = inj_vld && inj_rdy && sel_hi;
    pop_lo = inj_vld && inj_rdy && !sel_hi;
    state_nxt = (inj_vld && !inj_rdy) ? (sel_hi ? ST_LOCK_HI : ST_LOCK_LO) : ST_ARB;
    starve_nxt = (lo_empty || pop_lo) ? 8'd0 :
                 (pop_hi && starve_cnt < SMAX) ? starve_cnt + 8'd1 : starve_cnt;
  end

  // lock register and starvation counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_ARB;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      starve_cnt <= starve_nxt;
    end
endmodule

// File: tb/tb_maze_inj_buf.sv
// tb_maze_inj_buf: directed scoreboard bench for the injection buffer
module tb_maze_inj_buf;
  import maze_inj_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 1'b0;
  logic rst_n;
  logic pkt_in_vld, pkt_in_qos, pkt_in_rdy;
  logic [TYPE_W-1:0] pkt_in_type, inj_type;
  logic [ID_W-1:0] pkt_in_src, pkt_in_tgt, inj_src, inj_tgt;
  logic [FLIT_W-1:0] pkt_in_data, inj_data;
  logic inj_vld, inj_qos, inj_rdy;
  logic [CW-1:0] hi_cnt, lo_cnt;
  int checks = 0;
  int errors = 0;
  pkt_t exp_q[$];
  pkt_t got, want, p1, h1, h2, h3, h4, l1;

  maze_inj_buf #(.DEPTH(DEPTH), .STARVE_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in_vld(pkt_in_vld), .pkt_in_qos(pkt_in_qos), .pkt_in_type(pkt_in_type),
    .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt), .pkt_in_data(pkt_in_data),
    .pkt_in_rdy(pkt_in_rdy),
    .inj_vld(inj_vld), .inj_qos(inj_qos), .inj_type(inj_type), .inj_src(inj_src),
    .inj_tgt(inj_tgt), .inj_data(inj_data), .inj_rdy(inj_rdy),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pkt_t p);
    pkt_in_vld = 1'b1;
    {pkt_in_qos, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data} = p;
  endtask

  function automatic pkt_t mk(input logic qos, input logic [7:0] d);
    pkt_t p;
    p.qos = qos;
    p.typ = d[1:0];
    p.src = d[5:0] ^ 6'h15;
    p.tgt = d[7:2];
    p.data = d;
    return p;
  endfunction

  // scoreboard: every accepted output must match the next expected packet
  always @(negedge clk)
    if (rst_n && inj_vld && inj_rdy) begin
      got = {inj_qos, inj_type, inj_src, inj_tgt, inj_data};
      if (exp_q.size() == 0) chk("spurious_inj", 32'(got), 32'hFFFF_FFFF);
      else begin
        want = exp_q.pop_front();
        chk("inj_pkt", 32'(got), 32'(want));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pkt_in_vld = 1'b0;
    {pkt_in_qos, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data} = '0;
    inj_rdy = 1'b0;
    #3;
    chk("rst_rdy", 32'(pkt_in_rdy), 1);
    chk("rst_vld", 32'(inj_vld), 0);
    chk("rst_fields", 32'({inj_qos, inj_type, inj_src, inj_tgt, inj_data}), 0);
    chk("rst_hi_cnt", 32'(hi_cnt), 0);
    chk("rst_lo_cnt", 32'(lo_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;
    // single low packet, one cycle latency, then pop
    p1 = '{qos: 1'b0, typ: 2'b00, src: 6'd3, tgt: 6'd5, data: 8'hA5};
    drive(p1);
    chk("no_bypass", 32'(inj_vld), 0);
    tick;
    pkt_in_vld = 1'b0;
    chk("t1_lo_cnt", 32'(lo_cnt), 1);
    chk("t1_vld", 32'(inj_vld), 1);
    chk("t1_fields", 32'({inj_qos, inj_type, inj_src, inj_tgt, inj_data}), 32'(p1));
    exp_q.push_back(p1);
    inj_rdy = 1'b1;
    tick;
    inj_rdy = 1'b0;
    chk("t1_lo_cnt_pop", 32'(lo_cnt), 0);
    chk("t1_vld_empty", 32'(inj_vld), 0);
    // fill the high FIFO and confirm backpressure
    for (int i = 0; i < 4; i++) begin
      drive(mk(1'b1, 8'h10 + 8'(i)));
      exp_q.push_back(mk(1'b1, 8'h10 + 8'(i)));
      tick;
    end
    chk("t2_hi_cnt", 32'(hi_cnt), 4);
    chk("t2_rdy_full", 32'(pkt_in_rdy), 0);
    drive(mk(1'b1, 8'h77));
    tick;
    chk("t2_hi_no_push", 32'(hi_cnt), 4);
    drive(mk(1'b0, 8'h78));
    tick;
    pkt_in_vld = 1'b0;
    chk("t2_lo_no_push", 32'(lo_cnt), 0);
    inj_rdy = 1'b1;
    tick;
    chk("t2_rdy_back", 32'(pkt_in_rdy), 1);
    chk("t2_hi_cnt3", 32'(hi_cnt), 3);
    repeat (3) tick;
    inj_rdy = 1'b0;
    chk("t2_hi_drained", 32'(hi_cnt), 0);
    // stalled low packet keeps the lock while a high packet arrives
    l1 = mk(1'b0, 8'h31);
    h1 = mk(1'b1, 8'h32);
    drive(l1);
    tick;
    drive(h1);
    chk("t3_lo_shown", 32'(inj_qos), 0);
    tick;
    pkt_in_vld = 1'b0;
    chk("t3_hi_cnt", 32'(hi_cnt), 1);
    chk("t3_lock_data", 32'(inj_data), 32'(l1.data));
    tick;
    chk("t3_lock_qos", 32'(inj_qos), 0);
    chk("t3_lock_data2", 32'(inj_data), 32'(l1.data));
    exp_q.push_back(l1);
    exp_q.push_back(h1);
    inj_rdy = 1'b1;
    tick;
    chk("t3_hi_next", 32'(inj_qos), 1);
    tick;
    inj_rdy = 1'b0;
    chk("t3_empty", 32'(inj_vld), 0);
    // starvation guard with threshold 2: expected order H H L H H
    h1 = mk(1'b1, 8'h51);
    h2 = mk(1'b1, 8'h52);
    h3 = mk(1'b1, 8'h53);
    h4 = mk(1'b1, 8'h54);
    l1 = mk(1'b0, 8'h5A);
    exp_q.push_back(h1);
    exp_q.push_back(h2);
    exp_q.push_back(l1);
    exp_q.push_back(h3);
    exp_q.push_back(h4);
    drive(h1);
    tick;
    drive(h2);
    tick;
    drive(h3);
    tick;
    drive(l1);
    tick;
    chk("t4_hi_cnt", 32'(hi_cnt), 3);
    chk("t4_lo_cnt", 32'(lo_cnt), 1);
    drive(h4);
    inj_rdy = 1'b1;
    tick;
    pkt_in_vld = 1'b0;
    repeat (4) tick;
    inj_rdy = 1'b0;
    chk("t4_hi_done", 32'(hi_cnt), 0);
    chk("t4_lo_done", 32'(lo_cnt), 0);
    // streaming push and pop on the high queue
    inj_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(mk(1'b1, 8'h80 + 8'(i)));
      exp_q.push_back(mk(1'b1, 8'h80 + 8'(i)));
      tick;
      chk("t5_hi_cnt", 32'(hi_cnt), 1);
    end
    pkt_in_vld = 1'b0;
    tick;
    inj_rdy = 1'b0;
    chk("t5_drained", 32'(hi_cnt), 0);
    // asynchronous reset with both FIFOs occupied
    drive(mk(1'b1, 8'hC1));
    tick;
    drive(mk(1'b0, 8'hC2));
    tick;
    drive(mk(1'b1, 8'hC3));
    tick;
    drive(mk(1'b0, 8'hC4));
    tick;
    pkt_in_vld = 1'b0;
    chk("t6_hi_before", 32'(hi_cnt), 2);
    chk("t6_lo_before", 32'(lo_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", 32'(inj_vld), 0);
    chk("t6_hi_cnt", 32'(hi_cnt), 0);
    chk("t6_lo_cnt", 32'(lo_cnt), 0);
    chk("t6_rdy", 32'(pkt_in_rdy), 1);
    chk("t6_fields", 32'({inj_qos, inj_type, inj_src, inj_tgt, inj_data}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("t6_post_vld", 32'(inj_vld), 0);
    l1 = mk(1'b0, 8'hE7);
    drive(l1);
    exp_q.push_back(l1);
    inj_rdy = 1'b1;
    tick;
    pkt_in_vld = 1'b0;
    repeat (2) tick;
    inj_rdy = 1'b0;
    chk("scoreboard_left", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
